// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the multi-channel FIR datapath.
//   acc_width()  : accumulator width for a given data/coeff width and max taps
//   ch_width()   : channel index width (at least one bit)
//   ACC_W, CH_W  : those widths for the default configuration
//   fir_state_t  : controller state encoding
//   sat_round()  : round-half-up, arithmetic shift and saturate to out_w bits
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int COEFF_W_DEF  = 16;
   localparam int MAX_TAPS_DEF = 32;
   localparam int NUM_CH_DEF   = 4;

   function automatic int acc_width(input int dw, input int cw, input int mt);
      return dw + cw + $clog2(mt);
   endfunction

   function automatic int ch_width(input int nc);
      return (nc > 1) ? $clog2(nc) : 1;
   endfunction

   localparam int ACC_W = acc_width(DATA_W_DEF, COEFF_W_DEF, MAX_TAPS_DEF);
   localparam int CH_W  = ch_width(NUM_CH_DEF);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOAD    = 2'd1;
   localparam logic [1:0] ST_COMPUTE = 2'd2;
   localparam logic [1:0] ST_OUTPUT  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      LOAD    = ST_LOAD,
      COMPUTE = ST_COMPUTE,
      OUTPUT  = ST_OUTPUT
   } fir_state_t;

   typedef struct packed {
      logic signed [63:0] val;
      logic               sat;
   } sat_res_t;

   // acc is sign-extended to 64 bits by the caller; the accumulator never
   // approaches 64 bits, so adding the rounding constant cannot overflow.
   function automatic sat_res_t sat_round(input logic signed [63:0] acc,
                                          input int shift, input int out_w);
      logic signed [63:0] rnd;
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           res;
      rnd = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
      r   = (acc + rnd) >>> shift;
      hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (out_w - 1));
      res.val = r;
      res.sat = 1'b0;
      if (r > hi) begin
         res.val = hi;
         res.sat = 1'b1;
      end else if (r < lo) begin
         res.val = lo;
         res.sat = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fir_mc_datapath_if.sv
// -----------------------------------------------------------------------------
// fir_mc_datapath_if
// Configuration, coefficient, sample and result channels of the FIR datapath.
//   master : control side (drives cfg/coeff/sample, accepts results)
//   slave  : the datapath
// Signals: cfg_start, cfg_taps, cfg_done, cfg_error,
//          coeff_valid/ready/data, in_valid/ready/ch/data,
//          out_valid/ready/ch/data/sat
// -----------------------------------------------------------------------------
interface fir_mc_datapath_if #(
   parameter int DATA_W   = 16,
   parameter int COEFF_W  = 16,
   parameter int OUT_W    = 16,
   parameter int MAX_TAPS = 32,
   parameter int NUM_CH   = 4
);
   import fir_pkg::*;

   localparam int TW = $clog2(MAX_TAPS) + 1;
   localparam int CW = ch_width(NUM_CH);

   logic                      cfg_start;
   logic [TW-1:0]             cfg_taps;
   logic                      cfg_done;
   logic                      cfg_error;
   logic                      coeff_valid;
   logic                      coeff_ready;
   logic signed [COEFF_W-1:0] coeff_data;
   logic                      in_valid;
   logic                      in_ready;
   logic [CW-1:0]             in_ch;
   logic signed [DATA_W-1:0]  in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [CW-1:0]             out_ch;
   logic signed [OUT_W-1:0]   out_data;
   logic                      out_sat;

   modport master (
      output cfg_start, cfg_taps, coeff_valid, coeff_data,
             in_valid, in_ch, in_data, out_ready,
      input  cfg_done, cfg_error, coeff_ready, in_ready,
             out_valid, out_ch, out_data, out_sat
   );

   modport slave (
      input  cfg_start, cfg_taps, coeff_valid, coeff_data,
             in_valid, in_ch, in_data, out_ready,
      output cfg_done, cfg_error, coeff_ready, in_ready,
             out_valid, out_ch, out_data, out_sat
   );

endinterface

// File: rtl/fir_mac_lane.sv
// -----------------------------------------------------------------------------
// fir_mac_lane
// Combinational PAR-way multiply-add: sum of coeff[j]*samp[j] over enabled j.
//   coeff[PAR] : signed coefficients
//   samp[PAR]  : signed history samples
//   en         : per-lane tap enable (taps past the filter length are masked)
//   sum        : signed partial sum, ACC_W bits
// -----------------------------------------------------------------------------
module fir_mac_lane #(
   parameter int DATA_W  = 16,
   parameter int COEFF_W = 16,
   parameter int PAR     = 4,
   parameter int ACC_W   = 37
) (
   input  logic signed [COEFF_W-1:0] coeff [PAR],
   input  logic signed [DATA_W-1:0]  samp  [PAR],
   input  logic [PAR-1:0]            en,
   output logic signed [ACC_W-1:0]   sum
);

   localparam int PW = DATA_W + COEFF_W;

   logic signed [PW-1:0] prod;

   always_comb begin
      sum  = '0;
      prod = '0;
      for (int j = 0; j < PAR; j++) begin
         // full-precision product, then sign-extended into the accumulator
         prod = PW'(coeff[j]) * PW'(samp[j]);
         if (en[j]) sum = sum + ACC_W'(prod);
      end
   end

endmodule

// File: rtl/fir_mc_datapath.sv
// -----------------------------------------------------------------------------
// fir_mc_datapath
// Time-multiplexed multi-channel FIR. One sample is filtered at a time:
// the sample is stored in its channel's circular history, then
// ceil(T/PAR) compute cycles accumulate PAR taps each, one cycle scales
// the accumulator (round, shift, saturate) and the result is held until
// accepted downstream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fir_mc_datapath_if (config, coeff, in, out)
// -----------------------------------------------------------------------------
module fir_mc_datapath #(
   parameter int DATA_W   = 16,
   parameter int COEFF_W  = 16,
   parameter int OUT_W    = 16,
   parameter int MAX_TAPS = 32,
   parameter int PAR      = 4,
   parameter int NUM_CH   = 4,
   parameter int SHIFT    = 15
) (
   input  logic                clk,
   input  logic                rst,
   fir_mc_datapath_if.slave    bus
);
   import fir_pkg::*;

   localparam int AW = acc_width(DATA_W, COEFF_W, MAX_TAPS);
   localparam int TW = $clog2(MAX_TAPS) + 1;
   localparam int LW = $clog2(MAX_TAPS);
   localparam int CW = ch_width(NUM_CH);

   fir_state_t                state;
   logic [TW-1:0]             taps;
   logic [LW-1:0]             ptr;
   logic signed [COEFF_W-1:0] h      [MAX_TAPS];
   logic signed [DATA_W-1:0]  hist   [NUM_CH][MAX_TAPS];
   logic [LW-1:0]             wr_ptr [NUM_CH];
   logic [CW-1:0]             cur_ch;
   logic [LW-1:0]             newest;
   logic [TW-1:0]             cnt;
   logic signed [AW-1:0]      acc;

   logic                      done_r;
   logic                      err_r;
   logic                      ov_r;
   logic [CW-1:0]             och_r;
   logic signed [OUT_W-1:0]   od_r;
   logic                      sat_r;

   logic signed [COEFF_W-1:0] lane_coeff [PAR];
   logic signed [DATA_W-1:0]  lane_samp  [PAR];
   logic [PAR-1:0]            lane_en;
   logic signed [AW-1:0]      lane_sum;
   logic                      last_cyc;
   logic                      legal;
   sat_res_t                  sr;

   assign bus.coeff_ready = (state == LOAD);
   assign bus.in_ready    = (state == IDLE) && done_r && !bus.cfg_start;
   assign bus.cfg_done    = done_r;
   assign bus.cfg_error   = err_r;
   assign bus.out_valid   = ov_r;
   assign bus.out_ch      = och_r;
   assign bus.out_data    = od_r;
   assign bus.out_sat     = sat_r;

   assign legal = (bus.cfg_taps != '0) && (bus.cfg_taps <= TW'(MAX_TAPS));
   assign sr    = sat_round(64'(acc), SHIFT, OUT_W);

   // Tap addressing for the current compute cycle. Sample for tap k sits
   // k slots behind the newest entry, modulo the filter length.
   always_comb begin
      int base;
      int k;
      int s;
      base     = int'(cnt) * PAR;
      k        = 0;
      s        = 0;
      last_cyc = (base + PAR) >= int'(taps);
      lane_en  = '0;
      for (int j = 0; j < PAR; j++) begin
         k = base + j;
         s = int'(newest) - k;
         if (s < 0) s = s + int'(taps);
         lane_en[j]    = (k < int'(taps));
         lane_coeff[j] = h[k[LW-1:0]];
         lane_samp[j]  = hist[cur_ch][s[LW-1:0]];
      end
   end

   fir_mac_lane #(
      .DATA_W  (DATA_W),
      .COEFF_W (COEFF_W),
      .PAR     (PAR),
      .ACC_W   (AW)
   ) u_lane (
      .coeff (lane_coeff),
      .samp  (lane_samp),
      .en    (lane_en),
      .sum   (lane_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         taps   <= '0;
         ptr    <= '0;
         cur_ch <= '0;
         newest <= '0;
         cnt    <= '0;
         acc    <= '0;
         done_r <= 1'b0;
         err_r  <= 1'b0;
         ov_r   <= 1'b0;
         och_r  <= '0;
         od_r   <= '0;
         sat_r  <= 1'b0;
         for (int i = 0; i < MAX_TAPS; i++) h[i] <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            for (int i = 0; i < MAX_TAPS; i++) hist[c][i] <= '0;
         end
      end else begin
         err_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cfg_start) begin
                  if (legal) begin
                     // new length: old histories would mix lengths, drop them
                     taps   <= bus.cfg_taps;
                     ptr    <= '0;
                     done_r <= 1'b0;
                     state  <= LOAD;
                     for (int c = 0; c < NUM_CH; c++) begin
                        wr_ptr[c] <= '0;
                        for (int i = 0; i < MAX_TAPS; i++) hist[c][i] <= '0;
                     end
                  end else begin
                     err_r <= 1'b1;
                  end
               end else if (bus.in_valid && bus.in_ready) begin
                  hist[bus.in_ch][wr_ptr[bus.in_ch]] <= bus.in_data;
                  if ({1'b0, wr_ptr[bus.in_ch]} == taps - 1'b1)
                     wr_ptr[bus.in_ch] <= '0;
                  else
                     wr_ptr[bus.in_ch] <= wr_ptr[bus.in_ch] + 1'b1;
                  newest <= wr_ptr[bus.in_ch];
                  cur_ch <= bus.in_ch;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= COMPUTE;
               end
            end
            LOAD: begin
               if (bus.coeff_valid) begin
                  h[ptr] <= bus.coeff_data;
                  ptr    <= ptr + 1'b1;
                  if ({1'b0, ptr} == taps - 1'b1) begin
                     done_r <= 1'b1;
                     state  <= IDLE;
                  end
               end
            end
            COMPUTE: begin
               acc <= acc + lane_sum;
               cnt <= cnt + 1'b1;
               if (last_cyc) state <= OUTPUT;
            end
            OUTPUT: begin
               // first OUTPUT cycle registers the scaled result
               if (!ov_r) begin
                  od_r  <= OUT_W'(sr.val);
                  sat_r <= sr.sat;
                  och_r <= cur_ch;
                  ov_r  <= 1'b1;
               end else if (bus.out_ready) begin
                  ov_r  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mc_datapath.sv
// -----------------------------------------------------------------------------
// tb_fir_mc_datapath
// Scoreboard bench: a reference model computes each expected result when a
// sample is accepted; a monitor compares results as the datapath emits them.
// -----------------------------------------------------------------------------
module tb_fir_mc_datapath;
   localparam int DATA_W   = 16;
   localparam int COEFF_W  = 16;
   localparam int OUT_W    = 16;
   localparam int MAX_TAPS = 32;
   localparam int PAR      = 4;
   localparam int NUM_CH   = 4;
   localparam int SHIFT    = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fir_mc_datapath_if #(
      .DATA_W(DATA_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W),
      .MAX_TAPS(MAX_TAPS), .NUM_CH(NUM_CH)
   ) bus ();

   fir_mc_datapath #(
      .DATA_W(DATA_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W), .MAX_TAPS(MAX_TAPS),
      .PAR(PAR), .NUM_CH(NUM_CH), .SHIFT(SHIFT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model: shift-register histories, newest sample at index 0
   int mh [MAX_TAPS];
   int mx [NUM_CH][MAX_TAPS];
   int mt = 0;
   int cfg_h [MAX_TAPS];

   longint q_data [$];
   int     q_ch   [$];
   int     q_sat  [$];
   int     q_cyc  [$];
   int     q_lat  [$];

   task automatic check(input string tag, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic void model_out(input int ch, output longint r, output int sat);
      longint acc;
      longint num;
      longint d;
      acc = 0;
      for (int k = 0; k < mt; k++) acc += longint'(mh[k]) * longint'(mx[ch][k]);
      d   = longint'(1) << SHIFT;
      num = acc + d / 2;
      r   = num / d;
      if ((num % d != 0) && (num < 0)) r = r - 1;   // floor division
      sat = 0;
      if (r > 32767)  begin r = 32767;  sat = 1; end
      if (r < -32768) begin r = -32768; sat = 1; end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input int t);
      int g;
      bus.cfg_taps  = 6'(t);
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
      check("cfg_done_cleared", bus.cfg_done, 0);
      for (int i = 0; i < t; i++) begin
         bus.coeff_valid = 1'b1;
         bus.coeff_data  = COEFF_W'(cfg_h[i]);
         g = 0;
         while (!bus.coeff_ready && g < 50) begin tick(); g++; end
         if (!bus.coeff_ready) check("coeff_ready_timeout", bus.coeff_ready, 1);
         tick();
      end
      bus.coeff_valid = 1'b0;
      check("cfg_done_set", bus.cfg_done, 1);
      mt = t;
      for (int k = 0; k < MAX_TAPS; k++) mh[k] = (k < t) ? cfg_h[k] : 0;
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < MAX_TAPS; k++) mx[c][k] = 0;
   endtask

   task automatic send(input int ch, input int x);
      int     g;
      longint r;
      int     s;
      bus.in_valid = 1'b1;
      bus.in_ch    = 2'(ch);
      bus.in_data  = DATA_W'(x);
      #1;
      g = 0;
      while (!bus.in_ready && g < 200) begin tick(); g++; end
      if (!bus.in_ready) begin
         check("in_ready_timeout", bus.in_ready, 1);
      end else begin
         for (int k = MAX_TAPS - 1; k > 0; k--) mx[ch][k] = mx[ch][k-1];
         mx[ch][0] = x;
         model_out(ch, r, s);
         q_data.push_back(r);
         q_ch.push_back(ch);
         q_sat.push_back(s);
         q_cyc.push_back(cyc + 1);
         q_lat.push_back((mt + PAR - 1) / PAR + 1);
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q_data.size() != 0 && g < 400) begin tick(); g++; end
      check("drain", q_data.size(), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_coeff_ready"}, bus.coeff_ready, 0);
      check({tag, "_cfg_done"},    bus.cfg_done, 0);
      check({tag, "_cfg_error"},   bus.cfg_error, 0);
      check({tag, "_in_ready"},    bus.in_ready, 0);
      check({tag, "_out_valid"},   bus.out_valid, 0);
      check({tag, "_out_ch"},      bus.out_ch, 0);
      check({tag, "_out_data"},    bus.out_data, 0);
      check({tag, "_out_sat"},     bus.out_sat, 0);
   endtask

   // monitor: results compared against the scoreboard head every cycle
   // they are presented, popped on the accepting handshake
   logic prev_ov = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_ov = 1'b0;
         end else begin
            if (bus.out_valid) begin
               if (q_data.size() == 0) begin
                  check("spurious_out_valid", bus.out_valid, 0);
               end else begin
                  if (!prev_ov) check("latency", cyc - q_cyc[0], q_lat[0]);
                  check("out_data", bus.out_data, q_data[0]);
                  check("out_ch", bus.out_ch, q_ch[0]);
                  check("out_sat", bus.out_sat, q_sat[0]);
                  check("in_ready_busy", bus.in_ready, 0);
                  if (bus.out_ready) begin
                     void'(q_data.pop_front());
                     void'(q_ch.pop_front());
                     void'(q_sat.pop_front());
                     void'(q_cyc.pop_front());
                     void'(q_lat.pop_front());
                  end
               end
            end
            prev_ov = bus.out_valid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_start   = 1'b0;
      bus.cfg_taps    = '0;
      bus.coeff_valid = 1'b0;
      bus.coeff_data  = '0;
      bus.in_valid    = 1'b0;
      bus.in_ch       = '0;
      bus.in_data     = '0;
      bus.out_ready   = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      check_outputs_zero("reset");
      rst = 1'b0;
      tick();

      // basic impulse response, T=4 (h = 1,2,3,4 in units of 2^-3 after x=8)
      cfg_h[0] = 4096; cfg_h[1] = 8192; cfg_h[2] = 12288; cfg_h[3] = 16384;
      configure(4);
      send(0, 8);
      for (int i = 0; i < 4; i++) send(0, 0);
      drain();

      // channel isolation: ch0 impulse, ch2 step, interleaved
      configure(4);
      send(0, 800);
      send(2, 56);
      send(0, 0);
      send(2, 56);
      send(0, 0);
      send(0, 0);
      drain();

      // T=5 with PAR=4: two compute cycles, history wraps after 5 samples
      for (int k = 0; k < 5; k++) cfg_h[k] = 4096;
      configure(5);
      for (int i = 0; i < 7; i++) send(1, 24);
      drain();

      // rounding and saturation with a single tap
      begin
         int tbl_h [6];
         int tbl_x [6];
         tbl_h = '{32767, -32768, -32768, 16384, 16384, 32767};
         tbl_x = '{32767, -32768, 32767, 1, -1, -32768};
         for (int i = 0; i < 6; i++) begin
            cfg_h[0] = tbl_h[i];
            configure(1);
            send(0, tbl_x[i]);
            drain();
         end
      end
      // two taps so the sum saturates in both directions
      cfg_h[0] = -32768; cfg_h[1] = -32768;
      configure(2);
      send(3, 32767);
      send(3, 32767);
      drain();
      cfg_h[0] = 32767; cfg_h[1] = 32767;
      configure(2);
      send(3, 32767);
      send(3, 32767);
      drain();

      // backpressure: result held while out_ready is low
      cfg_h[0] = 4096; cfg_h[1] = 8192; cfg_h[2] = 12288; cfg_h[3] = 16384;
      configure(4);
      bus.out_ready = 1'b0;
      send(1, 8);
      for (int i = 0; i < 14; i++) tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      drain();
      tick();
      check("in_ready_after_release", bus.in_ready, 1);

      // illegal lengths: error pulse, configuration kept
      for (int i = 0; i < 2; i++) begin
         bus.cfg_taps  = (i == 0) ? 6'd0 : 6'(MAX_TAPS + 1);
         bus.cfg_start = 1'b1;
         #1;
         check("in_ready_during_cfg_start", bus.in_ready, 0);
         tick();
         bus.cfg_start = 1'b0;
         check("cfg_error_pulse", bus.cfg_error, 1);
         check("cfg_done_kept", bus.cfg_done, 1);
         tick();
         check("cfg_error_cleared", bus.cfg_error, 0);
      end
      send(1, 0);
      drain();

      // reset in the middle of a computation
      for (int k = 0; k < MAX_TAPS; k++) cfg_h[k] = 4096;
      configure(32);
      send(3, 100);
      tick();
      tick();
      rst = 1'b1;
      q_data.delete(); q_ch.delete(); q_sat.delete(); q_cyc.delete(); q_lat.delete();
      #1;
      check_outputs_zero("mid_reset");
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("post_reset_out_valid", bus.out_valid, 0);
      check("post_reset_cfg_done", bus.cfg_done, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
